// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared width default and FSM state type for the Gray counter
package gray_pkg;

    localparam int GRAY_SIZE = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/gray_counter_bin2gray.sv
// rtl/gray_counter_bin2gray.sv - combinational binary-to-Gray conversion, MSB-first
module bin2gray_
    import gray_pkg::*;
#(
    parameter int SIZE = GRAY_SIZE
) (
    input  logic [SIZE-1:0] bin,
    output logic [SIZE-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down binary counter offering its Gray code over a valid/ready handshake
module gray_counter
    import gray_pkg::*;
#(
    parameter int SIZE = GRAY_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic            up_dn,
    input  logic            load,
    input  logic [SIZE-1:0] load_val,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [SIZE-1:0] gray_o,
    output logic            wrap_o,
    output logic            err_o
);

    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    state_t          state_q;
    state_t          state_d;
    logic [SIZE-1:0] bin_q;
    logic [SIZE-1:0] bin_d;
    logic [SIZE-1:0] gray_d;
    logic [SIZE-1:0] gray_diff;
    logic            xfer;
    logic            step;
    logic            wrap_d;
    logic            hop_bad;

    assign out_valid = (state_q == RUN);
    assign xfer      = out_valid && out_ready;
    assign step      = xfer && !load;

    // stop outranks start so a simultaneous pair always lands in IDLE
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = RUN;
        end
    end

    // a load swallows any coinciding transfer and never reports a wrap
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (xfer) begin
            if (up_dn) begin
                bin_d  = bin_q + ONE;
                wrap_d = &bin_q;
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = ~|bin_q;
            end
        end
    end

    bin2gray_ #(.SIZE(SIZE)) u_bin2gray (
        .bin  (bin_d),
        .gray (gray_d)
    );

    // a legal step flips exactly one bit: diff nonzero and a power of two
    assign gray_diff = gray_d ^ gray_o;
    assign hop_bad   = (gray_diff == '0) || ((gray_diff & (gray_diff - ONE)) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            gray_o  <= '0;
            wrap_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_o  <= gray_d;
            wrap_o  <= wrap_d;
            if (step && hop_bad) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - self-checking bench for gray_counter against a behavioural model
module tb_gray_counter;

    localparam int SIZE = 10;
    localparam int MOD  = 1 << SIZE;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            stop;
    logic            up_dn;
    logic            load;
    logic [SIZE-1:0] load_val;
    logic            out_ready;
    logic            out_valid;
    logic [SIZE-1:0] gray_o;
    logic            wrap_o;
    logic            err_o;

    int checks;
    int failures;
    bit model_en;

    // behavioural model: running flag and integer count
    bit m_run;
    int m_cnt;
    bit m_wrap;

    gray_counter #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .gray_o    (gray_o),
        .wrap_o    (wrap_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gray_of(input int n);
        return n ^ (n >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  = 1'b0;
            m_cnt  = 0;
            m_wrap = 1'b0;
        end else begin
            int raw;
            bit xfer;
            xfer   = m_run && out_ready;
            m_wrap = 1'b0;
            if (load) begin
                m_cnt = int'(load_val);
            end else if (xfer) begin
                raw    = m_cnt + (up_dn ? 1 : -1);
                m_wrap = (raw < 0) || (raw >= MOD);
                m_cnt  = (raw + MOD) % MOD;
            end
            if (stop) m_run = 1'b0;
            else if (start) m_run = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && model_en) begin
            chk("cyc_valid", int'(out_valid), int'(m_run));
            chk("cyc_gray", int'(gray_o), gray_of(m_cnt));
            chk("cyc_wrap", int'(wrap_o), int'(m_wrap));
            chk("cyc_err", int'(err_o), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wraps;
        int errs;
        checks    = 0;
        failures  = 0;
        model_en  = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        up_dn     = 1'b1;
        load      = 1'b0;
        load_val  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_gray", int'(gray_o), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_wrap", int'(wrap_o), 0);
        chk("rst_err", int'(err_o), 0);
        rst_n    = 1'b1;
        model_en = 1'b1;
        tick();

        // count up from zero: 000 001 003 002 006
        start = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b1;
        chk("up_seq0", int'(gray_o), 'h000);
        chk("up_valid", int'(out_valid), 1);
        tick(); chk("up_seq1", int'(gray_o), 'h001); chk("up_wrap1", int'(wrap_o), 0);
        tick(); chk("up_seq2", int'(gray_o), 'h003);
        tick(); chk("up_seq3", int'(gray_o), 'h002);
        tick(); chk("up_seq4", int'(gray_o), 'h006); chk("up_wrap4", int'(wrap_o), 0);

        // load top value (with a coinciding transfer) then wrap upward
        load     = 1'b1;
        load_val = 10'h3FF;
        tick();
        load = 1'b0;
        chk("load_gray", int'(gray_o), 'h200);
        chk("load_wrap", int'(wrap_o), 0);
        tick();
        out_ready = 1'b0;
        chk("upwrap_gray", int'(gray_o), 'h000);
        chk("upwrap_pulse", int'(wrap_o), 1);
        tick();
        chk("upwrap_one", int'(wrap_o), 0);

        // down from zero wraps to the top
        up_dn     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("dnwrap_gray", int'(gray_o), 'h200);
        chk("dnwrap_pulse", int'(wrap_o), 1);

        // backpressure holds the value
        load     = 1'b1;
        load_val = 10'd9;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_gray", int'(gray_o), 'h00D);
        end
        up_dn     = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("resume_gray", int'(gray_o), 'h00F);

        // stop with a transfer at count 5
        load     = 1'b1;
        load_val = 10'd5;
        tick();
        load      = 1'b0;
        stop      = 1'b1;
        out_ready = 1'b1;
        tick();
        stop      = 1'b0;
        out_ready = 1'b0;
        chk("stop_gray", int'(gray_o), 'h005);
        chk("stop_valid", int'(out_valid), 0);

        // start and stop together: stop wins
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_valid", int'(out_valid), 0);

        // asynchronous reset mid-RUN
        start = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_gray", int'(gray_o), 0);
        chk("async_valid", int'(out_valid), 0);
        chk("async_wrap", int'(wrap_o), 0);
        chk("async_err", int'(err_o), 0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("resume_idle", int'(out_valid), 0);
        chk("resume_zero", int'(gray_o), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 9) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            up_dn     = ($urandom_range(0, 7) != 0) ? up_dn : ~up_dn;
            load      = ($urandom_range(0, 29) == 0);
            load_val  = SIZE'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;

        // full sweeps from zero, up then down
        load      = 1'b1;
        load_val  = '0;
        out_ready = 1'b0;
        tick();
        load  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            up_dn     = (d == 0);
            out_ready = 1'b1;
            wraps     = 0;
            errs      = 0;
            for (int i = 0; i < MOD; i++) begin
                tick();
                if (wrap_o) wraps++;
                if (err_o) errs++;
            end
            out_ready = 1'b0;
            chk(d == 0 ? "sweep_up_wraps" : "sweep_dn_wraps", wraps, 1);
            chk(d == 0 ? "sweep_up_err" : "sweep_dn_err", errs, 0);
            chk(d == 0 ? "sweep_up_end" : "sweep_dn_end", int'(gray_o), 0);
        end

        tick();
        model_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter SIZE, default 10, giving the count/Gray word width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  pulse; enters RUN.
REQ-005 SHALL have port stop  input  1  pulse; returns to IDLE.
REQ-006 SHALL have port up_dn  input  1  count direction: 1 = up, 0 = down.
REQ-007 SHALL have port load  input  1  loads load_val into the binary count.
REQ-008 SHALL have port load_val  input  SIZE  binary preset value.
REQ-009 SHALL have port out_ready  input  1  the downstream Gray-to-binary stage accepts gray_o.
REQ-010 SHALL have port out_valid  output  1  gray_o is offered.
REQ-011 SHALL have port gray_o  output  SIZE  Gray code of the internal binary count.
REQ-012 SHALL have port wrap_o  output  1  one-cycle pulse on count wrap-around.
REQ-013 SHALL have port err_o  output  1  sticky Hamming-distance violation flag.

Function
REQ-014 SHALL hold an internal SIZE-bit binary count bin_q and register gray_o = bin_q ^ (bin_q >> 1), so gray_o always matches bin_q (zero lag).
REQ-015 SHALL implement FSM states IDLE and RUN: IDLE->RUN on start; RUN->IDLE on stop; otherwise hold.
REQ-016 SHALL drive out_valid = 1 exactly while in RUN (registered state, no combinational path from start).
REQ-017 SHALL define a transfer as out_valid && out_ready on a rising edge.
REQ-018 SHALL step bin_q by +1 (up_dn=1) or -1 (up_dn=0) modulo 2^SIZE on each transfer, and never otherwise.
REQ-019 SHALL keep gray_o stable while out_valid=1 and out_ready=0.
REQ-020 SHALL pulse wrap_o for one cycle, coincident with the new gray_o, when a step takes bin_q 2^SIZE-1 -> 0 (up) or 0 -> 2^SIZE-1 (down).
REQ-021 SHALL give load priority over a step in any state: bin_q <= load_val next edge; no wrap_o pulse; FSM state unchanged.
REQ-022 SHALL count a transfer coinciding with load as consumed; the next offered value is Gray(load_val).
REQ-023 SHALL, on stop together with a transfer, apply the step and then enter IDLE.
REQ-024 SHALL, on start and stop together, give stop priority (stay/enter IDLE).
REQ-025 SHALL apply an up_dn change to the next step only.
REQ-026 SHALL set err_o when two consecutive stepped gray_o values differ in other than exactly one bit; load cycles are excluded; err_o clears only on reset.

Reset
REQ-027 SHALL, on rst_n=0, immediately (asynchronously) force FSM=IDLE, bin_q=0, gray_o=0, out_valid=0, wrap_o=0, err_o=0.
REQ-028 SHALL resume from IDLE with count 0 after rst_n deasserts, including after a reset mid-RUN.

Structure
REQ-029 SHALL place the default SIZE constant and the IDLE/RUN state typedef in the shared package gray_pkg.
REQ-030 SHALL instantiate one combinational sub-module bin2gray_ (parameter SIZE) for the binary-to-Gray conversion feeding the gray_o register.
REQ-031 SHALL keep the Gray-code output port-compatible with the existing Gray-to-binary converter input (same SIZE, MSB-first).

Verification
REQ-032 SHALL cover: reset, start, out_ready=1, up_dn=1 -> gray_o 0x000, 0x001, 0x003, 0x002, 0x006 on successive cycles; wrap_o=0.
REQ-033 SHALL cover: load, load_val=0x3FF -> gray_o=0x200; one up transfer -> gray_o=0x000, wrap_o=1 for one cycle.
REQ-034 SHALL cover: from count 0, up_dn=0, one transfer -> gray_o=0x200, wrap_o=1.
REQ-035 SHALL cover: in RUN, out_ready=0 for 3 cycles -> gray_o and bin_q unchanged; the step resumes on the first ready cycle.
REQ-036 SHALL cover: stop with a transfer at count 5 -> gray_o=Gray(6)=0x005, out_valid=0 next cycle; then rst_n pulse mid-RUN -> all outputs 0 without a clock edge.
REQ-037 SHALL cover: a full 1024-step up sweep and a full 1024-step down sweep -> err_o stays 0, and exactly one wrap_o per sweep.
